// File: rtl/prog_sequencer.sv
// prog_sequencer: byte-loaded instruction buffer replayed to a core, with loop, halt and done
module prog_sequencer #(
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       load_valid,
  input  logic [7:0]                 load_byte,
  output logic                       load_ready,
  input  logic                       clear,
  input  logic                       start,
  input  logic                       loop_en,
  input  logic                       halt,
  output logic [15:0]                instr_out,
  output logic                       instr_valid,
  output logic [$clog2(DEPTH)-1:0]   pc,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       busy,
  output logic                       done
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic {IDLE, RUN} state_t;
  state_t        state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [AW:0]   count_q, count_d;
  logic          phase_q, phase_d;
  logic [7:0]    staging_q, staging_d;
  logic          done_q, done_d;
  logic          we;
  logic          last;
  logic [15:0]   mem [DEPTH];
  assign busy        = state_q == RUN;
  assign load_ready  = !busy && count_q < (AW+1)'(DEPTH);
  assign instr_valid = busy;
  assign instr_out   = busy ? mem[pc_q] : 16'h0000;
  assign pc          = pc_q;
  assign count       = count_q;
  assign done        = done_q;
  assign last        = {1'b0, pc_q} == count_q - 1'b1;
  // next-state: loading and start in IDLE (clear wins), stepping/wrap/halt in RUN
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    count_d   = count_q;
    phase_d   = phase_q;
    staging_d = staging_q;
    done_d    = 1'b0;
    we        = 1'b0;
    if (!busy) begin
      if (clear) begin
        count_d = '0;
        phase_d = 1'b0;
      end else begin
        if (load_valid && load_ready) begin
          if (phase_q) begin
            we      = 1'b1;
            count_d = count_q + 1'b1;
            phase_d = 1'b0;
          end else begin
            staging_d = load_byte;
            phase_d   = 1'b1;
          end
        end
        if (start && count_q != '0 && !phase_q) begin
          state_d = RUN;
          pc_d    = '0;
        end
      end
    end else if (halt) begin
      state_d = IDLE;
      pc_d    = '0;
    end else if (last) begin
      pc_d    = '0;
      state_d = loop_en ? RUN : IDLE;
      done_d  = !loop_en;
    end else begin
      pc_d = pc_q + 1'b1;
    end
  end
  // control state with asynchronous reset; done is a registered one-cycle pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pc_q      <= '0;
      count_q   <= '0;
      phase_q   <= 1'b0;
      staging_q <= 8'h00;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      count_q   <= count_d;
      phase_q   <= phase_d;
      staging_q <= staging_d;
      done_q    <= done_d;
    end
  end
  // instruction slots hold no reset value; written when the high byte completes a word
  always_ff @(posedge clk) begin
    if (we) mem[count_q[AW-1:0]] <= {load_byte, staging_q};
  end
endmodule

// File: tb/tb_prog_sequencer.sv
// tb_prog_sequencer: directed checks of loading, run, loop, halt, clear and reset
module tb_prog_sequencer;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load_valid = 1'b0;
  logic [7:0]  load_byte = 8'h00;
  logic        load_ready;
  logic        clear = 1'b0;
  logic        start = 1'b0;
  logic        loop_en = 1'b0;
  logic        halt = 1'b0;
  logic [15:0] instr_out;
  logic        instr_valid;
  logic [2:0]  pc;
  logic [3:0]  count;
  logic        busy;
  logic        done;
  int checks = 0;
  int errors = 0;
  logic [15:0] loop_exp [6] = '{16'h2413, 16'h6857, 16'h2413, 16'h6857, 16'h2413, 16'h6857};

  prog_sequencer #(.DEPTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .load_valid(load_valid), .load_byte(load_byte),
    .load_ready(load_ready), .clear(clear), .start(start), .loop_en(loop_en),
    .halt(halt), .instr_out(instr_out), .instr_valid(instr_valid), .pc(pc),
    .count(count), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic put(input logic [7:0] b);
    load_valid = 1'b1;
    load_byte  = b;
    tick();
    load_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  initial begin
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_valid", instr_valid, 0);
    chk("rst_instr", instr_out, 0);
    chk("rst_ready", load_ready, 1);
    chk("rst_count", count, 0);
    chk("rst_pc", pc, 0);
    chk("rst_done", done, 0);
    tick();
    rst_n = 1'b1;
    tick();
    put(8'h13); put(8'h24); put(8'h57); put(8'h68);
    chk("ld_count", count, 2);
    pulse_start();
    chk("run0_instr", instr_out, 16'h2413);
    chk("run0_valid", instr_valid, 1);
    chk("run0_pc", pc, 0);
    chk("run0_busy", busy, 1);
    chk("run0_ready", load_ready, 0);
    tick();
    chk("run1_instr", instr_out, 16'h6857);
    chk("run1_pc", pc, 1);
    chk("run1_done", done, 0);
    tick();
    chk("end_done", done, 1);
    chk("end_busy", busy, 0);
    chk("end_valid", instr_valid, 0);
    chk("end_count", count, 2);
    chk("end_pc", pc, 0);
    tick();
    chk("end_done_drop", done, 0);
    loop_en = 1'b1;
    pulse_start();
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("loop%0d_instr", i), instr_out, loop_exp[i]);
      chk($sformatf("loop%0d_done", i), done, 0);
      tick();
    end
    halt = 1'b1;
    #0;
    chk("pre_halt_valid", instr_valid, 1);
    tick();
    halt = 1'b0;
    chk("halt_valid", instr_valid, 0);
    chk("halt_busy", busy, 0);
    chk("halt_pc", pc, 0);
    chk("halt_done", done, 0);
    tick();
    chk("halt_done2", done, 0);
    loop_en = 1'b0;
    pulse_start();
    chk("replay_instr", instr_out, 16'h2413);
    halt = 1'b1;
    tick();
    halt = 1'b0;
    chk("replay_halt", busy, 0);
    pulse_clear();
    chk("clr_count", count, 0);
    for (int i = 0; i < 16; i++) put(8'(i));
    chk("full_count", count, 8);
    chk("full_ready", load_ready, 0);
    put(8'hEE);
    chk("full_ignore", count, 8);
    pulse_start();
    chk("full_slot0", instr_out, 16'h0100);
    repeat (7) tick();
    chk("full_slot7", instr_out, 16'h0F0E);
    chk("full_pc7", pc, 7);
    tick();
    chk("full_done", done, 1);
    pulse_clear();
    chk("clr2_count", count, 0);
    chk("clr2_ready", load_ready, 1);
    put(8'h11);
    pulse_start();
    chk("half_start", busy, 0);
    put(8'h22);
    chk("half_count", count, 1);
    pulse_clear();
    pulse_start();
    chk("empty_start", busy, 0);
    put(8'h13); put(8'h24); put(8'h57); put(8'h68);
    pulse_start();
    tick();
    chk("mid_pc", pc, 1);
    rst_n = 1'b0;
    #1;
    chk("arst_valid", instr_valid, 0);
    chk("arst_busy", busy, 0);
    chk("arst_pc", pc, 0);
    chk("arst_count", count, 0);
    rst_n = 1'b1;
    tick();
    pulse_start();
    chk("arst_start", busy, 0);
    put(8'h77);
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    tick();
    put(8'hAA); put(8'hBB);
    chk("ldrst_count", count, 1);
    pulse_start();
    chk("ldrst_instr", instr_out, 16'hBBAA);
    tick();
    chk("ldrst_done", done, 1);
    clear = 1'b1; load_valid = 1'b1; load_byte = 8'h55; start = 1'b1;
    tick();
    clear = 1'b0; load_valid = 1'b0; start = 1'b0;
    chk("cls_count", count, 0);
    chk("cls_busy", busy, 0);
    put(8'h66);
    chk("cls_phase", count, 0);
    put(8'h77);
    chk("cls_phase2", count, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/prog_sequencer.md
PROG_SEQUENCER -- requirements
Module: prog_sequencer

Interface
REQ-001 Parameter DEPTH, default 8, number of 16-bit instruction slots (power of two, 2..16).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 load_valid  input  1  byte-write strobe for program load.
REQ-005 load_byte  input  8  program byte; low byte of an instruction first, then high byte.
REQ-006 load_ready  output  1  byte accepted when load_valid && load_ready.
REQ-007 clear  input  1  empties the program buffer.
REQ-008 start  input  1  begins execution of the loaded program.
REQ-009 loop_en  input  1  after the last slot, wrap to slot 0 instead of stopping.
REQ-010 halt  input  1  aborts execution.
REQ-011 instr_out  output  16  instruction presented to the core: {uio byte, ui byte}.
REQ-012 instr_valid  output  1  instr_out is meaningful this cycle.
REQ-013 pc  output  log2(DEPTH)  index of the slot currently presented.
REQ-014 count  output  log2(DEPTH)+1  number of complete instructions loaded.
REQ-015 busy  output  1  high while in RUN.
REQ-016 done  output  1  one-cycle pulse on normal completion.

Function
REQ-017 Two states SHALL exist: IDLE and RUN; busy = (state == RUN).
REQ-018 In IDLE, load_ready SHALL be (count < DEPTH); in RUN, load_ready SHALL be 0 and load_valid SHALL be ignored.
REQ-019 Accepted byte with phase=0 SHALL be stored in a staging register and set phase to 1.
REQ-020 Accepted byte with phase=1 SHALL write {load_byte, staging} into slot[count], increment count, and clear phase.
REQ-021 clear in IDLE SHALL set count=0 and phase=0 next cycle, with priority over a simultaneous load or start; clear in RUN SHALL be ignored.
REQ-022 start in IDLE SHALL be accepted only if count != 0 and phase == 0; otherwise it is ignored with no state change.
REQ-023 Accepted start SHALL set state=RUN and pc=0; slot 0 appears on instr_out with instr_valid=1 in the following cycle.
REQ-024 In RUN, instr_out SHALL equal slot[pc] combinationally and instr_valid SHALL be 1; outside RUN both SHALL be 0.
REQ-025 In RUN with pc < count-1 and no halt, pc SHALL increment by 1 each cycle.
REQ-026 In RUN with pc == count-1: if loop_en=1, pc SHALL wrap to 0 and stay in RUN; else state SHALL return to IDLE, pc to 0, and done SHALL pulse high for exactly the next cycle.
REQ-027 halt in RUN SHALL return state to IDLE and pc to 0 next cycle, with no done pulse; halt has priority over increment, wrap and completion.
REQ-028 halt and start asserted in IDLE SHALL be ignored/start wins respectively (halt has no effect in IDLE).
REQ-029 count and program contents SHALL be preserved across RUN so start may replay without reloading.
REQ-030 loop_en SHALL be sampled each cycle at the pc == count-1 decision only.

Reset
REQ-031 On rst_n low, asynchronously: state=IDLE, pc=0, count=0, phase=0, staging=0, done=0; hence instr_valid=0, instr_out=0, busy=0, load_ready=1.
REQ-032 Slot storage SHALL NOT require reset; contents are undefined until written.
REQ-033 Reset asserted mid-RUN or mid-load (phase=1) SHALL abandon the operation; after release the block is in IDLE with an empty buffer.

Verification
REQ-034 Load bytes 0x13,0x24,0x57,0x68 then start (loop_en=0) -> instr_out 0x2413 then 0x6857 on consecutive cycles, pc 0,1, then done=1 one cycle, busy=0, count=2.
REQ-035 Same program, loop_en=1, run 6 cycles -> instr_out 0x2413,0x6857,0x2413,0x6857,0x2413,0x6857, no done; halt -> instr_valid=0 next cycle, no done.
REQ-036 Load DEPTH=8 full instructions -> count=8, load_ready=0; further load_valid ignored; clear -> count=0, load_ready=1.
REQ-037 Load one byte only, pulse start -> ignored (busy stays 0); start with count=0 -> ignored.
REQ-038 Assert rst_n=0 in RUN at pc=1 -> immediately instr_valid=0, busy=0, pc=0, count=0; after release start is ignored until a program is reloaded.
REQ-039 clear, load_valid and start in the same IDLE cycle -> count=0, phase=0, state stays IDLE.
